// File: rtl/step_sequencer.sv
// step_sequencer: fetch/execute step FSM steering an external 4-bit step counter.
// Rev 1.0 -- initial release.
`default_nettype none

module step_sequencer #(
  parameter int FETCH_STEPS = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       halt_req,
  input  logic       resume,
  input  logic [3:0] op_len,
  input  logic [3:0] step_q,
  input  logic       step_zero,
  output logic       cnt_clr,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       exec_en,
  output logic       done,
  output logic       busy,
  output logic       halted,
  output logic       err,
  output logic [3:0] exec_step
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] C_FETCH_N    = 4'(FETCH_STEPS);
  localparam logic [3:0] C_FETCH_LAST = 4'(FETCH_STEPS - 1);
  localparam logic [3:0] C_LEN_MAX    = 4'(16 - FETCH_STEPS);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_len;
  logic       r_halt_pend;
  logic       r_err;
  logic       r_cnt_clr;
  logic [3:0] w_len_eff;
  logic [3:0] w_exec_last;
  logic       w_fetch_last;
  logic       w_halt_now;

  // Clamp keeps FETCH_STEPS+L-1 within 15 so the counter never wraps in EXEC.
  always_comb begin
    w_len_eff = (op_len == 4'd0) ? 4'd1 : op_len;
    if (w_len_eff > C_LEN_MAX) w_len_eff = C_LEN_MAX;
  end

  assign w_exec_last  = C_FETCH_N + r_len - 4'd1;
  assign w_fetch_last = (r_state == S_FETCH) && (step_q == C_FETCH_LAST);
  assign w_halt_now   = r_halt_pend | halt_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: w_next = w_fetch_last ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (step_zero)                 w_next = S_HALT;
        else if (step_q == w_exec_last) w_next = S_DONE;
        else                           w_next = S_EXEC;
      end
      S_DONE: begin
        if (w_halt_now) w_next = S_HALT;
        else if (run)   w_next = S_FETCH;
        else            w_next = S_IDLE;
      end
      S_HALT:  w_next = (resume && !r_err) ? S_FETCH : S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_cnt_clr   <= 1'b1;
      r_len       <= 4'd0;
      r_halt_pend <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt_clr <= (w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_HALT);
      if (w_fetch_last) r_len <= w_len_eff;
      if (w_next == S_HALT)
        r_halt_pend <= 1'b0;
      else if (halt_req && ((r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_DONE)))
        r_halt_pend <= 1'b1;
      if ((r_state == S_EXEC) && step_zero) r_err <= 1'b1;
    end
  end

  assign cnt_clr   = r_cnt_clr;
  assign ir_load   = w_fetch_last;
  assign pc_inc    = w_fetch_last;
  assign exec_en   = (r_state == S_EXEC);
  assign exec_step = exec_en ? (step_q - C_FETCH_N) : 4'd0;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_DONE);
  assign halted    = (r_state == S_HALT);
  assign err       = r_err;

endmodule

`default_nettype wire
